// File: rtl/morse_pkg.sv
// Shared constants, FSM state and result type for the Morse receive path.
package morse_pkg;

  localparam logic [2:0] LTR_S = 3'd0;
  localparam logic [2:0] LTR_T = 3'd1;
  localparam logic [2:0] LTR_U = 3'd2;
  localparam logic [2:0] LTR_V = 3'd3;
  localparam logic [2:0] LTR_W = 3'd4;
  localparam logic [2:0] LTR_X = 3'd5;
  localparam logic [2:0] LTR_Y = 3'd6;
  localparam logic [2:0] LTR_Z = 3'd7;

  localparam int DASH_MIN_UNITS   = 2;
  localparam int MARK_MAX_UNITS   = 3;
  localparam int LETTER_GAP_UNITS = 3;
  localparam int MAX_SYMBOLS      = 4;

  typedef enum logic [1:0] {IDLE, MARK, GAP, EMIT} state_t;

  typedef struct packed {
    logic       valid;
    logic       err;
    logic [2:0] code;
  } letter_t;

endpackage

// File: rtl/morse_unit_timer.sv
// Free-running Morse unit strobe: one-cycle tick every UNIT_CYCLES clocks.
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 25000000
) (
  input  logic clock_50,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(UNIT_CYCLES);

  logic [CW-1:0] count;

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset)              count <= CW'(UNIT_CYCLES - 1);
    else if (count == '0)   count <= CW'(UNIT_CYCLES - 1);
    else                    count <= count - CW'(1);
  end

  assign tick = (count == '0);

endmodule

// File: rtl/morse_decoder.sv
// Samples a keyed Morse line once per unit and decodes letters S..Z to a 3-bit code.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 25000000
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       key_in,
  output logic       letter_valid,
  output logic [2:0] letter_code,
  output logic       letter_err,
  output logic       busy
);

  logic key_meta, key_s, tick;

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      key_meta <= 1'b0;
      key_s    <= 1'b0;
    end else begin
      key_meta <= key_in;
      key_s    <= key_meta;
    end
  end

  morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
    .clock_50 (clock_50),
    .reset    (reset),
    .tick     (tick)
  );

  state_t     state, state_nxt;
  logic [3:0] sym_bits;
  logic [2:0] sym_cnt;
  logic [2:0] mark_run;
  logic [1:0] gap_run;
  logic       err;
  letter_t    res, res_nxt;
  logic [2:0] lut_code;
  logic       lut_hit;

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (tick && key_s) state_nxt = MARK;
      MARK: if (tick && !key_s) state_nxt = GAP;
      GAP: if (tick) begin
        if (key_s)                                   state_nxt = MARK;
        else if (gap_run == 2'(LETTER_GAP_UNITS-1))  state_nxt = EMIT;
      end
      EMIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Symbol assembly; a mark is classified when the first space sample arrives.
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      sym_bits <= '0;
      sym_cnt  <= '0;
      mark_run <= '0;
      gap_run  <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (tick && key_s) mark_run <= 3'd1;
        MARK: if (tick) begin
          if (key_s) begin
            if (mark_run != 3'(MARK_MAX_UNITS+1)) mark_run <= mark_run + 3'd1;
          end else begin
            gap_run <= 2'd1;
            if (mark_run > 3'(MARK_MAX_UNITS) || sym_cnt == 3'(MAX_SYMBOLS)) err <= 1'b1;
            if (sym_cnt != 3'(MAX_SYMBOLS)) begin
              sym_bits <= {sym_bits[2:0], (mark_run >= 3'(DASH_MIN_UNITS))};
              sym_cnt  <= sym_cnt + 3'd1;
            end
          end
        end
        GAP: if (tick) begin
          if (key_s) begin
            mark_run <= 3'd1;
            gap_run  <= 2'd0;
          end else begin
            gap_run  <= gap_run + 2'd1;
          end
        end
        EMIT: begin
          sym_bits <= '0;
          sym_cnt  <= '0;
          mark_run <= '0;
          gap_run  <= '0;
          err      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lut_hit  = 1'b1;
    lut_code = LTR_S;
    case ({sym_cnt, sym_bits})
      {3'd3, 4'b0000}: lut_code = LTR_S;
      {3'd1, 4'b0001}: lut_code = LTR_T;
      {3'd3, 4'b0001}: lut_code = LTR_U;
      {3'd4, 4'b0001}: lut_code = LTR_V;
      {3'd3, 4'b0011}: lut_code = LTR_W;
      {3'd4, 4'b1001}: lut_code = LTR_X;
      {3'd4, 4'b1011}: lut_code = LTR_Y;
      {3'd4, 4'b1100}: lut_code = LTR_Z;
      default:         lut_hit  = 1'b0;
    endcase
  end

  // Result is registered on the GAP->EMIT edge so it is visible during EMIT.
  always_comb begin
    res_nxt = '0;
    if (state == GAP && state_nxt == EMIT) begin
      res_nxt.valid = 1'b1;
      res_nxt.err   = err || !lut_hit;
      res_nxt.code  = res_nxt.err ? LTR_S : lut_code;
    end
  end

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) res <= '0;
    else       res <= res_nxt;
  end

  assign letter_valid = res.valid;
  assign letter_code  = res.code;
  assign letter_err   = res.err;
  assign busy         = (state != IDLE);

endmodule

// File: doc/morse_decoder.md
# morse_decoder

Receive-side counterpart of the lab's Morse encoder: samples a single on/off key line once per Morse unit, classifies marks as dot or dash, groups symbols into letters on a 3-unit gap, and reports the decoded letter as the same 3-bit choice code the encoder's switch input uses (S..Z). It sits between a synchronised key or LED-loopback input and display logic (HEX/LEDR), and closes the loop for encoder/decoder board tests.

## Interface
- UNIT_CYCLES, 25000000: clock_50 cycles per Morse unit (0.5 s at 50 MHz); ≥ 2.
- clock_50  in  1  system clock, all state on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- key_in  in  1  Morse line, 1 = mark (on), 0 = space; asynchronous to clock_50.
- letter_valid  out  1  one-cycle pulse, letter result present.
- letter_code  out  3  000=S 001=T 010=U 011=V 100=W 101=X 110=Y 111=Z; valid while letter_valid.
- letter_err  out  1  with letter_valid: pattern illegal; letter_code = 000.
- busy  out  1  high while a letter is being assembled (not IDLE).

## Operation
- key_in passes a 2-flop synchroniser; sampled value used only on unit ticks.
- Unit tick: one-cycle strobe every UNIT_CYCLES clocks; timer free-runs, not aligned to key edges.
- Symbols: dot = 0, dash = 1, shifted into sym_bits[3:0] LSB-first-in (newest at bit 0); sym_cnt counts 0..4.
- Mark run (consecutive 1 samples): 1 unit -> dot; 2 or 3 units -> dash; ≥4 -> set err flag (run counter saturates at 4).
- Gap run (consecutive 0 samples after a mark): 1 or 2 units -> intra-letter, next 1 sample starts new symbol; 3rd 0 sample -> end of letter.
- Symbol committed on the first 0 sample after a mark. A 5th symbol sets err flag; sym_bits unchanged.
- Lookup (cnt, bits): S 3,000; T 1,1; U 3,001; V 4,0001; W 3,011; X 4,1001; Y 4,1011; Z 4,1100. Any other pair -> err.
- FSM: IDLE (wait for 1 sample; busy=0) -> MARK (count mark) -> GAP on 0 sample (commit symbol) -> MARK on 1 sample if gap<3, EMIT on 3rd gap unit -> IDLE. EMIT lasts one clock.
- Leaving EMIT clears sym_bits, sym_cnt, err flag, run counters.
- Long space in IDLE: no output. Key held high forever: stays in MARK, no output.

## Timing
- Reset values: letter_valid 0, letter_code 000, letter_err 0, busy 0; FSM IDLE; timer reloaded to UNIT_CYCLES-1.
- Reset mid-letter: partial letter discarded, no letter_valid pulse.
- Input latency: key edge visible to FSM at first tick ≥2 clocks after edge.
- letter_valid, letter_code, letter_err registered: asserted in the clock cycle after the tick sampling the 3rd gap unit, for exactly one cycle; letter_code/letter_err return to 0 afterwards.
- busy rises the cycle after the tick that samples the first mark; falls with letter_valid's falling edge.
- Minimum spacing between letter_valid pulses: 5 units (1 mark + 3 gap + 1 restart).
- No backpressure: consumer must capture on the pulse.

## Structure
- Package morse_pkg: letter code constants (LTR_S..LTR_Z), DASH_MIN_UNITS=2, MARK_MAX_UNITS=3, LETTER_GAP_UNITS=3, MAX_SYMBOLS=4, FSM state enum (IDLE, MARK, GAP, EMIT).
- Sub-module morse_unit_timer: parameter UNIT_CYCLES, ports clock_50, reset, tick; down-counter, tick when count = 0, reload UNIT_CYCLES-1. Shared with future encoder revisions.
- Lookup is a combinational case inside morse_decoder.

## Test plan
Sim with UNIT_CYCLES=4; stimulus edges aligned to ticks.
- S (1u on,1u off ×3, then 3u off) -> one letter_valid, code 000, err 0, busy low afterwards.
- Z (3on 1off 3on 1off 1on 1off 1on 3off) -> code 111, err 0; V (...-) -> 011.
- T, 3u gap, U -> two pulses 001 then 010, 5+ units apart; a 2-unit intra-letter gap in U still yields 010.
- Mark of 5 units then 3u off -> letter_valid with err 1, code 000.
- Five dots then 3u off -> err 1; pattern -- (2 dashes, undefined) -> err 1.
- reset pulsed after two dots of S -> all outputs 0, no pulse; next full W (.--) decodes to 100.
